// File: rtl/mem_bus_ctrl.sv
// Single-master memory bus controller: accepts one read/write request at a time and
// sequences SETUP / STROBE / HOLD phases on a shared tri-state data bus.
module mem_bus_ctrl #(
  parameter int STROBE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       we,
  input  logic [5:0] addr_in,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic [5:0] address,
  output logic       READ,
  output logic       WRITE,
  inout  wire  [7:0] data
);

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 2;
  localparam int unsigned STROBE_N = (STROBE_CYCLES < 1) ? 1 :
                                     (STROBE_CYCLES > 4) ? 4 : unsigned'(STROBE_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STROBE_N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            read_q, read_d;
  logic            write_q, write_d;
  logic            drive_q, drive_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            accept_c;

  // A request is only taken once ready is visible, so the first post-reset edge never accepts.
  assign accept_c = (state_q == S_IDLE) && ready_q && req;

  // State register and transaction latches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and strobe-length counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          we_d    = we;
          addr_d  = addr_in;
          wdata_d = wdata;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so they can be registered without extra latency
  always_comb begin
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_HOLD);
    read_d  = (state_d == S_STROBE) && !we_d;
    write_d = (state_d == S_STROBE) && we_d;
    drive_d = (state_d != S_IDLE) && we_d;
    rdata_d = rdata_q;
    if ((state_q == S_STROBE) && (cnt_q == '0) && read_q) begin
      rdata_d = data;
    end
  end

  // Output registers; reset clears strobes and releases the bus without waiting for clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      drive_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= ready_d;
      done_q  <= done_d;
      read_q  <= read_d;
      write_q <= write_d;
      drive_q <= drive_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign READ    = read_q;
  assign WRITE   = write_q;
  assign rdata   = rdata_q;
  assign address = addr_q;
  assign data    = drive_q ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: two instances (strobe 1 and 3) each with a small memory model.
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       req1, req3, we;
  logic [5:0] addr_in;
  logic [7:0] wdata;

  logic       ready1, done1, READ1, WRITE1;
  logic [7:0] rdata1;
  logic [5:0] address1;
  tri0  [7:0] data1;

  logic       ready3, done3, READ3, WRITE3;
  logic [7:0] rdata3;
  logic [5:0] address3;
  tri0  [7:0] data3;

  logic [7:0] mem1 [64];
  logic [7:0] mem3 [64];

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_ctrl #(.STROBE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we), .addr_in(addr_in), .wdata(wdata),
    .ready(ready1), .done(done1), .rdata(rdata1), .address(address1),
    .READ(READ1), .WRITE(WRITE1), .data(data1)
  );

  mem_bus_ctrl #(.STROBE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .we(we), .addr_in(addr_in), .wdata(wdata),
    .ready(ready3), .done(done3), .rdata(rdata3), .address(address3),
    .READ(READ3), .WRITE(WRITE3), .data(data3)
  );

  // Memory side: drives the bus only during READ, captures on clk while WRITE
  assign data1 = READ1 ? mem1[address1] : 8'hzz;
  assign data3 = READ3 ? mem3[address3] : 8'hzz;
  always @(posedge clk) if (WRITE1) mem1[address1] <= data1;
  always @(posedge clk) if (WRITE3) mem3[address3] <= data3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every cycle: strobes exclusive, and a read bus carries exactly the memory value (no contention)
  always @(negedge clk) begin
    if (!reset) begin
      check_eq("rw_excl1", 32'(READ1 & WRITE1), 32'd0);
      check_eq("rw_excl3", 32'(READ3 & WRITE3), 32'd0);
      if (READ1) check_eq("rd_bus1", 32'(data1), 32'(mem1[address1]));
      if (READ3) check_eq("rd_bus3", 32'(data3), 32'(mem3[address3]));
    end
  end

  logic [7:0] exp_rd [3];
  int rd_cnt, rd_first, done_at, n_done;

  initial begin
    req1 = 1'b0; req3 = 1'b0; we = 1'b0; addr_in = '0; wdata = 8'hC3;
    for (int i = 0; i < 64; i++) begin
      mem1[i] = 8'(i);
      mem3[i] = 8'(i);
    end
    mem1[6'h05] = 8'hA7; mem1[6'h11] = 8'h55; mem1[6'h10] = 8'h99;
    mem1[6'h00] = 8'h11; mem1[6'h04] = 8'h44; mem1[6'h08] = 8'h88;
    mem3[6'h3F] = 8'h5A;
    exp_rd[0] = 8'h11; exp_rd[1] = 8'h44; exp_rd[2] = 8'h88;

    // Reset state
    tick(); tick();
    check_eq("rst_ready", 32'(ready1), 32'd0);
    check_eq("rst_done", 32'(done1), 32'd0);
    check_eq("rst_read", 32'(READ1), 32'd0);
    check_eq("rst_write", 32'(WRITE1), 32'd0);
    check_eq("rst_addr", 32'(address1), 32'h00);
    check_eq("rst_rdata", 32'(rdata1), 32'h00);
    check_eq("rst_bus", 32'(data1), 32'h00);
    check_eq("rst_ready3", 32'(ready3), 32'd0);
    reset = 1'b0;
    check_eq("rel_ready_early", 32'(ready1), 32'd0);
    tick();
    check_eq("rel_ready1", 32'(ready1), 32'd1);
    check_eq("rel_ready3", 32'(ready3), 32'd1);

    // Read of 0x05, strobe 1
    we = 1'b0; addr_in = 6'h05; req1 = 1'b1;
    tick();
    req1 = 1'b0; addr_in = 6'h3E;
    check_eq("rd_c1_addr", 32'(address1), 32'h05);
    check_eq("rd_c1_read", 32'(READ1), 32'd0);
    check_eq("rd_c1_ready", 32'(ready1), 32'd0);
    check_eq("rd_c1_bus", 32'(data1), 32'h00);
    tick();
    check_eq("rd_c2_read", 32'(READ1), 32'd1);
    check_eq("rd_c2_done", 32'(done1), 32'd0);
    tick();
    check_eq("rd_c3_read", 32'(READ1), 32'd0);
    check_eq("rd_c3_done", 32'(done1), 32'd1);
    check_eq("rd_c3_rdata", 32'(rdata1), 32'hA7);
    tick();
    check_eq("rd_c4_ready", 32'(ready1), 32'd1);
    check_eq("rd_c4_done", 32'(done1), 32'd0);
    check_eq("rd_c4_addr", 32'(address1), 32'h05);

    // Write 0x3C to 0x2A; inputs change after acceptance
    we = 1'b1; addr_in = 6'h2A; wdata = 8'h3C; req1 = 1'b1;
    tick();
    req1 = 1'b0; we = 1'b0; addr_in = 6'h00; wdata = 8'hFF;
    check_eq("wr_c1_addr", 32'(address1), 32'h2A);
    check_eq("wr_c1_write", 32'(WRITE1), 32'd0);
    check_eq("wr_c1_bus", 32'(data1), 32'h3C);
    tick();
    check_eq("wr_c2_write", 32'(WRITE1), 32'd1);
    check_eq("wr_c2_read", 32'(READ1), 32'd0);
    check_eq("wr_c2_bus", 32'(data1), 32'h3C);
    tick();
    check_eq("wr_c3_write", 32'(WRITE1), 32'd0);
    check_eq("wr_c3_done", 32'(done1), 32'd1);
    check_eq("wr_c3_bus", 32'(data1), 32'h3C);
    check_eq("wr_c3_rdata_hold", 32'(rdata1), 32'hA7);
    tick();
    check_eq("wr_c4_ready", 32'(ready1), 32'd1);
    check_eq("wr_c4_bus", 32'(data1), 32'h00);
    check_eq("wr_mem", 32'(mem1[6'h2A]), 32'h3C);

    // Read back 0x2A; controller must not drive during the read
    we = 1'b0; addr_in = 6'h2A; req1 = 1'b1;
    tick();
    req1 = 1'b0;
    check_eq("rb_c1_bus", 32'(data1), 32'h00);
    tick();
    check_eq("rb_c2_read", 32'(READ1), 32'd1);
    check_eq("rb_c2_bus", 32'(data1), 32'h3C);
    tick();
    check_eq("rb_c3_rdata", 32'(rdata1), 32'h3C);
    check_eq("rb_c3_done", 32'(done1), 32'd1);
    check_eq("rb_c3_bus", 32'(data1), 32'h00);
    tick();

    // Strobe 3: read 0x3F
    we = 1'b0; addr_in = 6'h3F; req3 = 1'b1;
    tick();
    req3 = 1'b0;
    rd_cnt = 0; rd_first = 0; done_at = 0; n_done = 0;
    for (int c = 1; c <= 7; c++) begin
      if (READ3) begin
        rd_cnt++;
        if (rd_first == 0) rd_first = c;
      end
      if (done3) begin
        n_done++;
        done_at = c;
      end
      if (c == 6) check_eq("s3_ready_c6", 32'(ready3), 32'd1);
      tick();
    end
    check_eq("s3_read_len", 32'(rd_cnt), 32'd3);
    check_eq("s3_read_first", 32'(rd_first), 32'd2);
    check_eq("s3_done_cycle", 32'(done_at), 32'd5);
    check_eq("s3_done_count", 32'(n_done), 32'd1);
    check_eq("s3_rdata", 32'(rdata3), 32'h5A);

    // Back-to-back with req held high: accepts at E0, E4, E8 only
    we = 1'b0; addr_in = 6'h00; req1 = 1'b1; n_done = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      addr_in = 6'(i);
      if (i == 9) req1 = 1'b0;
      check_eq($sformatf("b2b_ready_c%0d", i), 32'(ready1),
               32'((i % 4 == 0) || (i >= 12)));
      check_eq($sformatf("b2b_done_c%0d", i), 32'(done1),
               32'((i == 3) || (i == 7) || (i == 11)));
      if (done1 && n_done < 3) begin
        check_eq($sformatf("b2b_rdata_%0d", n_done), 32'(rdata1), 32'(exp_rd[n_done]));
        n_done++;
      end else if (done1) begin
        n_done++;
      end
    end
    check_eq("b2b_done_count", 32'(n_done), 32'd3);

    // Prior read leaves rdata=0x55, then reset during the strobe of a read to 0x10
    addr_in = 6'h11; req1 = 1'b1;
    tick();
    req1 = 1'b0;
    tick(); tick();
    check_eq("pre_rdata", 32'(rdata1), 32'h55);
    tick();
    addr_in = 6'h10; req1 = 1'b1;
    tick();
    req1 = 1'b0;
    tick();
    check_eq("ab_read_on", 32'(READ1), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ab_read_off", 32'(READ1), 32'd0);
    check_eq("ab_bus", 32'(data1), 32'h00);
    check_eq("ab_rdata", 32'(rdata1), 32'h00);
    check_eq("ab_done", 32'(done1), 32'd0);
    check_eq("ab_ready", 32'(ready1), 32'd0);
    tick();
    check_eq("ab_done_edge", 32'(done1), 32'd0);
    reset = 1'b0;
    check_eq("ab_ready_rel", 32'(ready1), 32'd0);
    tick();
    check_eq("ab_ready_after", 32'(ready1), 32'd1);
    check_eq("ab_done_after", 32'(done1), 32'd0);
    check_eq("ab_addr_after", 32'(address1), 32'h00);
    tick();
    check_eq("ab_done_late", 32'(done1), 32'd0);
    check_eq("ab_rdata_late", 32'(rdata1), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter: STROBE_CYCLES, default 1, READ/WRITE high time in clocks; legal 1-4; values above 4 SHALL be treated as 4 and values below 1 as 1.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  1  transaction request; sampled only while ready=1.
REQ-005 Port: we  input  1  1 = write, 0 = read; sampled with req.
REQ-006 Port: addr_in  input  6  target address; sampled with req.
REQ-007 Port: wdata  input  8  write data; sampled with req.
REQ-008 Port: ready  output  1  controller idle, can accept req.
REQ-009 Port: done  output  1  one-cycle completion pulse.
REQ-010 Port: rdata  output  8  last read result; holds until the next read completes.
REQ-011 Port: address  output  6  memory address bus.
REQ-012 Port: READ  output  1  memory read strobe.
REQ-013 Port: WRITE  output  1  memory write strobe.
REQ-014 Port: data  inout  8  shared memory data bus.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, STROBE and HOLD.
REQ-016 ready SHALL be 1 only in IDLE with reset deasserted.
REQ-017 IDLE: on an edge with req=1, the controller SHALL latch we, addr_in and wdata and go to SETUP; with req=0 it SHALL stay in IDLE.
REQ-018 SETUP: lasts exactly 1 cycle; address is driven from the latch and READ=WRITE=0; then go to STROBE.
REQ-019 STROBE: lasts exactly STROBE_CYCLES cycles, counted by a 2-bit down-counter; READ=1 for a read or WRITE=1 for a write, never both; then go to HOLD.
REQ-020 Read capture: on the edge leaving STROBE, while READ is still 1, rdata SHALL load data.
REQ-021 HOLD: lasts 1 cycle; READ=WRITE=0; address is still held; done=1; then go to IDLE.
REQ-022 Latency: with the accept edge E0, done SHALL be high in the cycle after edge E(1+STROBE_CYCLES), and ready SHALL return after edge E(2+STROBE_CYCLES).
REQ-023 Back-to-back: with req held high, transactions SHALL repeat every STROBE_CYCLES+3 cycles; there is no acceptance during SETUP, STROBE or HOLD.
REQ-024 req asserted while ready=0 SHALL be ignored and not queued.
REQ-025 The data bus SHALL be driven with the latched wdata only in SETUP, STROBE and HOLD of a write; otherwise it SHALL be high-Z, so it is never driven while READ=1.
REQ-026 address SHALL hold its last transaction value in IDLE.
REQ-027 READ, WRITE and done SHALL be registered outputs, free of glitches.
REQ-028 A change on addr_in, we or wdata after acceptance SHALL NOT affect the transaction in flight.

Reset
REQ-029 While reset=1, the block SHALL be in IDLE with ready=0, done=0, READ=0, WRITE=0, address=6'h00, rdata=8'h00, counter=0 and data at high-Z.
REQ-030 Reset asserted mid-transaction SHALL drop READ/WRITE and release data immediately, without waiting for clk; the aborted transaction SHALL produce no done pulse and SHALL NOT update rdata.
REQ-031 ready SHALL rise in the first cycle after reset deasserts; the first req is accepted on the following edge.

Verification
REQ-032 Read, STROBE_CYCLES=1, memory loaded mem[6'h05]=8'hA7: pulse req=1, we=0, addr_in=6'h05 -> address=6'h05 from cycle 1, READ high exactly cycle 2, done high cycle 3 with rdata=8'hA7, ready=1 cycle 4.
REQ-033 Write then read: write 8'h3C to 6'h2A, then read 6'h2A -> WRITE is a single-cycle pulse while data=8'h3C; read returns rdata=8'h3C; data is high-Z throughout the read.
REQ-034 STROBE_CYCLES=3: read 6'h3F -> READ high for exactly 3 cycles; done occurs 5 cycles after the accept edge.
REQ-035 req held high for 3 transactions (STROBE_CYCLES=1) -> accepts spaced exactly 4 cycles apart; requests during busy are not queued; exactly 3 done pulses.
REQ-036 Reset asserted during the STROBE of a read to 6'h10 with a prior rdata=8'h55 -> READ falls before the next clk edge; rdata=8'h00; no done; ready=1 one cycle after release.
REQ-037 The bench SHALL check every cycle that READ and WRITE are never both 1 and that data is high-Z whenever READ=1 from the controller side.
